// File: rtl/afe_integrator_inverse_filter_if.sv
// Sample stream, coefficient programming and status bundle for one
// integrator inverse-filter channel.
interface afe_integrator_inverse_filter_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18
);
    logic                     enable;
    logic                     n_1_reset;
    logic                     bypass;
    logic signed [DATA_W-1:0] x;
    logic                     coef_wr_en;
    logic [2:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_apply;
    logic                     coef_busy;
    logic signed [DATA_W-1:0] y;
    logic                     y_valid;
    logic                     sat_flag;

    modport master (
        output enable, n_1_reset, bypass, x,
        output coef_wr_en, coef_addr, coef_wdata, coef_apply,
        input  coef_busy, y, y_valid, sat_flag
    );

    modport slave (
        input  enable, n_1_reset, bypass, x,
        input  coef_wr_en, coef_addr, coef_wdata, coef_apply,
        output coef_busy, y, y_valid, sat_flag
    );
endinterface

// File: rtl/afe_integrator_inverse_filter.sv
// Programmable second-order DF-I IIR that undoes the AFE integrator response,
// with a shadow coefficient bank swapped atomically and a post-swap settle window.
module afe_integrator_inverse_filter #(
    parameter int DATA_W         = 16,
    parameter int COEF_W         = 18,
    parameter int COEF_FRAC      = 15,
    parameter int ACC_W          = 48,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    afe_integrator_inverse_filter_if.slave bus
);

    localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    localparam logic [CNT_W-1:0]         SETTLE_INIT = CNT_W'(SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0]         CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1'b1);
    localparam logic signed [DATA_W-1:0] DATA_ZERO   = {DATA_W{1'b0}};
    localparam logic signed [COEF_W-1:0] COEF_ZERO   = {COEF_W{1'b0}};
    localparam logic signed [COEF_W-1:0] COEF_ONE    = COEF_W'(1'b1) <<< COEF_FRAC;
    localparam logic signed [ACC_W-1:0]  ACC_RND     = ACC_W'(1'b1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]  Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWAP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // Round half-up, drop the fraction, clamp; MSB of the result flags a clamp.
    function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = (acc + ACC_RND) >>> COEF_FRAC;
        if (sh > Y_MAX) begin
            round_sat = {1'b1, Y_MAX[DATA_W-1:0]};
        end else if (sh < Y_MIN) begin
            round_sat = {1'b1, Y_MIN[DATA_W-1:0]};
        end else begin
            round_sat = {1'b0, sh[DATA_W-1:0]};
        end
    endfunction

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         settle_cnt_q, settle_cnt_d;
    logic                     busy_q, busy_d;
    logic                     swap_s, settling_s;

    logic signed [COEF_W-1:0] coef_act_q [0:4];
    logic signed [COEF_W-1:0] coef_shd_q [0:4];

    logic signed [DATA_W-1:0] x_i_q, x1_q, x2_q, y1_q, y2_q, xb_q, y_q;
    logic                     en_q, byp_q, sup_q, y_valid_q, sat_q;

    logic signed [ACC_W-1:0]  acc_s;
    logic [DATA_W:0]          rs_s;
    logic signed [DATA_W-1:0] res_s;
    logic                     ovf_s;

    // FSM state register plus registered busy indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            settle_cnt_q <= CNT_ZERO;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
        end
    end

    // FSM next state; a cleared strobe (n_1_reset) does not consume a settle slot.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.coef_apply) state_d = ST_SWAP;
                else                state_d = ST_RUN;
            end
            ST_SWAP: begin
                settle_cnt_d = SETTLE_INIT;
                if (SETTLE_SAMPLES == 32'sd0) state_d = ST_RUN;
                else                          state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.enable && !bus.n_1_reset) begin
                    settle_cnt_d = settle_cnt_q - CNT_ONE;
                    if (settle_cnt_q == CNT_ONE) state_d = ST_RUN;
                    else                         state_d = ST_SETTLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d      = ST_RUN;
                settle_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // FSM output decode.
    always_comb begin
        swap_s     = 1'b0;
        settling_s = 1'b0;
        case (state_q)
            ST_RUN:    begin swap_s = 1'b0; settling_s = 1'b0; end
            ST_SWAP:   swap_s     = 1'b1;
            ST_SETTLE: settling_s = 1'b1;
            default:   begin swap_s = 1'b0; settling_s = 1'b0; end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    // Coefficient banks: shadow takes every write, active only changes on a swap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                coef_shd_q[i] <= COEF_ZERO;
                coef_act_q[i] <= COEF_ZERO;
            end
            coef_shd_q[0] <= COEF_ONE;
            coef_act_q[0] <= COEF_ONE;
        end else begin
            if (swap_s) begin
                coef_act_q <= coef_shd_q;
            end
            for (int i = 0; i < 5; i++) begin
                if (bus.coef_wr_en && (bus.coef_addr == 3'(i))) begin
                    coef_shd_q[i] <= bus.coef_wdata;
                end
            end
        end
    end

    // Input history and the strobe that launches the output stage one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_i_q <= DATA_ZERO;
            x1_q  <= DATA_ZERO;
            x2_q  <= DATA_ZERO;
            xb_q  <= DATA_ZERO;
            en_q  <= 1'b0;
            byp_q <= 1'b0;
            sup_q <= 1'b0;
        end else if (bus.n_1_reset || swap_s) begin
            x_i_q <= DATA_ZERO;
            x1_q  <= DATA_ZERO;
            x2_q  <= DATA_ZERO;
            en_q  <= 1'b0;
        end else if (bus.enable) begin
            en_q  <= 1'b1;
            byp_q <= bus.bypass;
            sup_q <= settling_s;
            xb_q  <= bus.x;
            if (!bus.bypass) begin
                x_i_q <= bus.x;
                x1_q  <= x_i_q;
                x2_q  <= x1_q;
            end
        end else begin
            en_q <= 1'b0;
        end
    end

    // Multiply-accumulate over the current history with the active bank.
    always_comb begin
        acc_s = ACC_W'(coef_act_q[0]) * ACC_W'(x_i_q)
              + ACC_W'(coef_act_q[1]) * ACC_W'(x1_q)
              + ACC_W'(coef_act_q[2]) * ACC_W'(x2_q)
              - ACC_W'(coef_act_q[3]) * ACC_W'(y1_q)
              - ACC_W'(coef_act_q[4]) * ACC_W'(y2_q);
        rs_s  = round_sat(acc_s);
        res_s = rs_s[DATA_W-1:0];
        ovf_s = rs_s[DATA_W];
    end

    // Output stage; y1/y2 hold the true recurrence even while the visible y is muted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y1_q      <= DATA_ZERO;
            y2_q      <= DATA_ZERO;
            y_q       <= DATA_ZERO;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else if (bus.n_1_reset) begin
            y1_q      <= DATA_ZERO;
            y2_q      <= DATA_ZERO;
            y_q       <= DATA_ZERO;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            y_valid_q <= en_q & ~sup_q;
            if (en_q) begin
                if (sup_q)      y_q <= DATA_ZERO;
                else if (byp_q) y_q <= xb_q;
                else            y_q <= res_s;
            end
            if (en_q && !byp_q && ovf_s) begin
                sat_q <= 1'b1;
            end
            if (swap_s) begin
                y1_q <= DATA_ZERO;
                y2_q <= DATA_ZERO;
            end else if (en_q && !byp_q) begin
                y1_q <= res_s;
                y2_q <= y1_q;
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.sat_flag  = sat_q;
    assign bus.coef_busy = busy_q;

endmodule

// File: doc/afe_integrator_inverse_filter.md
Name: afe_integrator_inverse_filter

Overview:
- Second-order direct-form-I IIR, run-time programmable, that undoes the AFE integrator response: it restores the pre-integrator pulse shape in front of the self-trigger.
- Coefficients are written into a shadow bank and swapped atomically at a sample boundary, followed by a settle interval with output suppressed.
- Sits per channel, between the ADC/AFE sample stream and the trigger filters.

Parameters:
- DATA_W, 16, input/output sample width (signed).
- COEF_W, 18, coefficient width (signed Q2.15).
- COEF_FRAC, 15, coefficient fractional bits.
- ACC_W, 48, accumulator width.
- SETTLE_SAMPLES, 4, enable strobes suppressed after a coefficient swap.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- enable  in  1  sample strobe; one sample is processed per enable-high cycle
- n_1_reset  in  1  synchronous clear of filter history
- bypass  in  1  1 = pass x through, registered
- x  in  DATA_W  signed input sample
- coef_wr_en  in  1  write coef_wdata to shadow[coef_addr]
- coef_addr  in  3  0..4 = c0,c1,c2,c3,c4; 5..7 ignored
- coef_wdata  in  COEF_W  signed Q2.15 value
- coef_apply  in  1  single-cycle pulse requesting shadow-to-active swap
- coef_busy  out  1  high during swap/settle
- y  out  DATA_W  signed output sample
- y_valid  out  1  one-cycle pulse per valid output sample
- sat_flag  out  1  sticky saturation indicator

Behaviour:
- Reset (async, reset_n=0):
  - Active and shadow banks load pass-through: c0=0x08000 (1.0); c1..c4=0.
  - x_i, x1, x2, y, y2, y_valid, sat_flag, coef_busy are all 0; state is RUN.
- Equation: acc = c0*x_i + c1*x1 + c2*x2 - c3*y1 - c4*y2, computed in ACC_W.
  - y1 is the current y register; y2 is the previous y.
  - Result = (acc + 2^14) >>> 15, arithmetic shift, then saturated to [-32768, 32767].
  - When saturation occurs: sat_flag <= 1. It clears only on reset_n or n_1_reset.
- Pipeline, RUN state, bypass=0:
  - Enable at cycle T: x_i <= x and x1 <= x_i, x2 <= x1.
  - T+1: y <= result, y2 <= y, y_valid=1 for that cycle.
  - Latency is 2 clocks from x to y. Recurrence closes in one clock.
  - Enable low: all history holds, y holds, y_valid=0.
- Bypass=1: on enable, y <= x at T+1 with y_valid=1; history registers hold. Leaving bypass resumes from the held history.
- n_1_reset: clears x_i, x1, x2, y, y2, sat_flag next clock. It has priority over enable and does not touch coefficients or state.
- Coefficient writes: shadow is written whenever coef_wr_en=1, including while busy; active coefficients are unaffected. coef_addr 5..7 is a no-op.
- FSM:
  - RUN: coef_apply=1 -> SWAP.
  - SWAP: one clock; active <= shadow, history cleared, settle counter <= SETTLE_SAMPLES -> SETTLE.
  - SETTLE: each enable strobe runs the filter normally (history updates), but y is forced to 0 and y_valid=0. The counter decrements per strobe; on reaching 0 -> RUN.
  - coef_busy=1 in SWAP and SETTLE.
- Boundary conditions:
  - coef_apply while busy is ignored.
  - coef_apply coinciding with enable in RUN: that sample is processed with the old coefficients; the swap occurs the next clock.
  - coef_wr_en and coef_apply in the same cycle: the write lands first, so the swap includes it.
  - n_1_reset during SETTLE clears history only; the counter continues.
  - reset_n mid-settle returns to RUN with pass-through coefficients.
  - SETTLE_SAMPLES=0: SWAP goes straight to RUN.

Test Plan:
- After reset: x=1000 with enable at T -> y=1000, y_valid=1 at T+2. Then x=-32768 -> y=-32768; sat_flag stays 0.
- Write c3=0x3C000 (-0.5), apply, wait for busy=0. Then impulse x=16384 followed by zeros -> y=16384, 8192, 4096, 2048, 1024.
- Write c0=0x10000 (2.0), apply. x=20000 -> y=32767, sat_flag=1. A following x=0 -> y=0 with sat_flag still 1. Pulse n_1_reset -> sat_flag=0.
- coef_apply with enable continuous -> coef_busy=1 for 1+4 cycles, 4 strobes with y=0 and y_valid=0, then the first filtered output. A second coef_apply while busy changes nothing.
- bypass=1 with x=-5 -> y=-5 next cycle and history unchanged. n_1_reset mid-stream -> y=0, and the next output is computed from zero history.
- reset_n low mid-SETTLE -> coef_busy=0 immediately and pass-through restored: x=77 -> y=77.
